// File: rtl/execute_cycle_pkg.sv
// Shared encodings for the execute stage: ALU operation codes and
// operand forwarding selects. Decode, hazard unit and execute all import
// this package so the encodings cannot drift apart.
package execute_cycle_pkg;

    // ALU operation select carried on ALUControlE
    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_op_e;

    // Operand source select driven by the hazard unit.
    // Code 2'b11 is unused and falls back to the register file operand.
    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    // Signed less-than, returned as a full-width 0/1 result
    function automatic logic [31:0] slt32(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] res;
        if ($signed(a) < $signed(b)) begin
            res = 32'd1;
        end else begin
            res = 32'd0;
        end
        return res;
    endfunction

endpackage

// File: rtl/execute_cycle_alu.sv
// 32-bit ALU for the execute stage. Add/sub wrap modulo 2^32 and no
// overflow flag exists; unassigned opcodes produce zero.
module alu
    import execute_cycle_pkg::*;
(
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  ALUControl,
    output logic [31:0] Result,
    output logic        Zero
);

    logic [31:0] result_s;

    // Operation select; anything outside the defined set yields zero
    always_comb begin
        result_s = 32'd0;
        case (ALUControl)
            ALU_ADD: result_s = A + B;
            ALU_SUB: result_s = A - B;
            ALU_AND: result_s = A & B;
            ALU_OR:  result_s = A | B;
            ALU_SLT: result_s = slt32(A, B);
            default: result_s = 32'd0;
        endcase
    end

    assign Result = result_s;
    assign Zero   = (result_s == 32'd0);

endmodule

// File: rtl/execute_cycle.sv
// Execute stage of the 5-stage pipeline: operand forwarding muxes, ALU,
// branch decision/target, and the Execute->Memory pipeline register.
// Branch outputs are combinational so the fetch stage can redirect in the
// same cycle; everything headed for Memory is registered.
module execute_cycle
    import execute_cycle_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteE,
    input  logic        MemWriteE,
    input  logic        ResultSrcE,
    input  logic        BranchE,
    input  logic        ALUSrcE,
    input  logic [2:0]  ALUControlE,
    input  logic [31:0] RD1_E,
    input  logic [31:0] RD2_E,
    input  logic [31:0] Imm_Ext_E,
    input  logic [31:0] PCE,
    input  logic [31:0] PCPlus4E,
    input  logic [4:0]  RD_E,
    input  logic [1:0]  ForwardA_E,
    input  logic [1:0]  ForwardB_E,
    input  logic [31:0] ResultW,
    output logic        PCSrcE,
    output logic [31:0] PCTargetE,
    output logic        RegWriteM,
    output logic        MemWriteM,
    output logic        ResultSrcM,
    output logic [4:0]  RD_M,
    output logic [31:0] PCPlus4M,
    output logic [31:0] WriteDataM,
    output logic [31:0] ALU_ResultM
);

    logic [31:0] src_a_s;
    logic [31:0] fwd_b_s;
    logic [31:0] src_b_s;
    logic [31:0] alu_result_s;
    logic        zero_s;

    logic        reg_write_m_r;
    logic        mem_write_m_r;
    logic        result_src_m_r;
    logic [4:0]  rd_m_r;
    logic [31:0] pc_plus4_m_r;
    logic [31:0] write_data_m_r;
    logic [31:0] alu_result_m_r;

    // Operand A forwarding; the MEM path uses the value currently held in
    // the E/M register so a back-to-back dependency needs no bubble
    always_comb begin
        src_a_s = RD1_E;
        case (ForwardA_E)
            FWD_REG: src_a_s = RD1_E;
            FWD_WB:  src_a_s = ResultW;
            FWD_MEM: src_a_s = alu_result_m_r;
            default: src_a_s = RD1_E;
        endcase
    end

    // Operand B forwarding; this value is also the store data
    always_comb begin
        fwd_b_s = RD2_E;
        case (ForwardB_E)
            FWD_REG: fwd_b_s = RD2_E;
            FWD_WB:  fwd_b_s = ResultW;
            FWD_MEM: fwd_b_s = alu_result_m_r;
            default: fwd_b_s = RD2_E;
        endcase
    end

    // Immediate vs. register operand for the ALU B input
    always_comb begin
        src_b_s = fwd_b_s;
        if (ALUSrcE) begin
            src_b_s = Imm_Ext_E;
        end else begin
            src_b_s = fwd_b_s;
        end
    end

    alu u_alu (
        .A          (src_a_s),
        .B          (src_b_s),
        .ALUControl (ALUControlE),
        .Result     (alu_result_s),
        .Zero       (zero_s)
    );

    // beq-style branch decision and target, unregistered
    assign PCSrcE    = BranchE & zero_s;
    assign PCTargetE = PCE + Imm_Ext_E;

    // E/M pipeline register; reset squashes the instruction in Execute
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_write_m_r  <= 1'b0;
            mem_write_m_r  <= 1'b0;
            result_src_m_r <= 1'b0;
            rd_m_r         <= 5'd0;
            pc_plus4_m_r   <= 32'd0;
            write_data_m_r <= 32'd0;
            alu_result_m_r <= 32'd0;
        end else begin
            reg_write_m_r  <= RegWriteE;
            mem_write_m_r  <= MemWriteE;
            result_src_m_r <= ResultSrcE;
            rd_m_r         <= RD_E;
            pc_plus4_m_r   <= PCPlus4E;
            write_data_m_r <= fwd_b_s;
            alu_result_m_r <= alu_result_s;
        end
    end

    assign RegWriteM   = reg_write_m_r;
    assign MemWriteM   = mem_write_m_r;
    assign ResultSrcM  = result_src_m_r;
    assign RD_M        = rd_m_r;
    assign PCPlus4M    = pc_plus4_m_r;
    assign WriteDataM  = write_data_m_r;
    assign ALU_ResultM = alu_result_m_r;

endmodule

// File: doc/execute_cycle.md
EXECUTE_CYCLE -- requirements
Module: execute_cycle

Interface
REQ-001 clk  in  1  single clock; all state updates on posedge clk.
REQ-002 rst  in  1  reset, synchronous and active-high.
REQ-003 RegWriteE, MemWriteE, ResultSrcE, BranchE, ALUSrcE  in  1 each  decoded controls for the instruction in Execute.
REQ-004 ALUControlE  in  3  ALU operation select.
REQ-005 RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E  in  32 each  register operands, sign-extended immediate, PC, PC+4.
REQ-006 RD_E  in  5  destination register index.
REQ-007 ForwardA_E, ForwardB_E  in  2 each  operand source select from the hazard unit.
REQ-008 ResultW  in  32  Writeback result, used for forwarding.
REQ-009 PCSrcE  out  1  branch taken (combinational, same cycle).
REQ-010 PCTargetE  out  32  branch target PCE+Imm_Ext_E (combinational).
REQ-011 RegWriteM, MemWriteM, ResultSrcM  out  1 each  registered controls for Memory stage.
REQ-012 RD_M  out  5;  PCPlus4M, WriteDataM, ALU_ResultM  out  32 each  registered E/M pipeline outputs.

Function
REQ-013 Operand A SHALL be RD1_E when ForwardA_E=00, ResultW when 01, ALU_ResultM (current registered output) when 10; 11 SHALL behave as 00.
REQ-014 Forwarded operand B SHALL use the same encoding on RD2_E; WriteData SHALL be forwarded B, before the immediate mux.
REQ-015 SrcB SHALL be Imm_Ext_E when ALUSrcE=1, else forwarded B.
REQ-016 ALUControlE: 000 add, 001 sub, 010 and, 011 or, 101 signed set-less-than (result 0 or 1); others SHALL yield 0.
REQ-017 Add/sub SHALL wrap modulo 2^32; no overflow flag is produced.
REQ-018 Zero SHALL be 1 iff the 32-bit ALU result equals 0.
REQ-019 PCSrcE SHALL equal BranchE AND Zero (beq semantics); PCTargetE SHALL wrap modulo 2^32.
REQ-020 E/M register: on each posedge with rst=0, RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM and ALU_ResultM SHALL load their Execute-stage values; latency exactly 1 cycle.
REQ-021 PCSrcE and PCTargetE SHALL NOT be registered here.
REQ-022 Forwarding path 10 SHALL use the pre-edge value of ALU_ResultM (back-to-back dependency resolves with no bubble).

Reset
REQ-023 When rst=1 at a posedge, all registered outputs SHALL become 0 (controls 0, RD_M 5'b0, 32-bit outputs 32'h00000000).
REQ-024 Reset asserted mid-stream SHALL discard the instruction in Execute; no control bit in M SHALL be 1 on the cycle after reset.
REQ-025 Reset SHALL NOT affect combinational outputs except through ALU_ResultM forwarding.

Structure
REQ-026 ALU opcode constants (ADD, SUB, AND, OR, SLT) and forward-select encodings SHALL live in a shared package used by decode, hazard unit and this block.
REQ-027 The ALU SHALL be a separate sub-module named alu (inputs A, B, ALUControl; outputs Result, Zero); muxes and E/M register stay in execute_cycle.

Verification
REQ-028 Reset: rst=1 for one edge with random inputs -> all M outputs 0 next cycle.
REQ-029 Add/wrap: RD1_E=32'hFFFFFFFF, Imm_Ext_E=1, ALUSrcE=1, ALUControlE=000 -> ALU_ResultM=0 next cycle.
REQ-030 SLT signed: RD1_E=32'hFFFFFFFE (-2), RD2_E=1, ALUControlE=101 -> ALU_ResultM=1; swapped operands -> 0.
REQ-031 Branch: BranchE=1, RD1_E=RD2_E=7, ALUControlE=001, PCE=32'h100, Imm_Ext_E=32'hFFFFFFF8 -> PCSrcE=1, PCTargetE=32'hF8 same cycle; with RD2_E=8 -> PCSrcE=0.
REQ-032 Forwarding: cycle n add 5+3 (ALU_ResultM=8 after edge); cycle n+1 ForwardA_E=10, RD2_E=2, sub -> ALU_ResultM=6; ForwardB_E=01, ResultW=9, MemWriteE=1 -> WriteDataM=9.
REQ-033 Mid-stream reset: stream of RegWriteE=1 instructions, assert rst one cycle -> RegWriteM=0 that cycle, resumes next instruction after rst drops.
